// File: rtl/tm_pkg.sv
// Shared types for the Turing machine input sequencer and the machine itself.
// The state and phase encodings are kept explicit so both sides agree on them.
package tm_pkg;

  localparam int TM_DATA_W = 6;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_SETUP  = 4'd2,
    ST_PRESS  = 4'd3,
    ST_GAP    = 4'd4,
    ST_DPRESS = 4'd5,
    ST_DGAP   = 4'd6,
    ST_STEP   = 4'd7,
    ST_SGAP   = 4'd8,
    ST_FINISH = 4'd9
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_PROG = 2'd0,
    PH_TAPE = 2'd1,
    PH_RUN  = 2'd2
  } seq_phase_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int timer_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tm_press_timer.sv
// Load/count/expire down-counter shared by every timed sequencer state.
// A load value of 0 behaves like 1 so a state always lasts at least one cycle.
module tm_press_timer
  import tm_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? '0 : load_val - 1'b1;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/tm_input_sequencer.sv
// Replays a stored program and tape image through the Turing machine's
// input_data/Next/Done button protocol, then steps the machine until it halts.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | address stable, then capture mem_data into input_data
// SETUP  | word held before the Next press
// PRESS  | Next high
// GAP    | Next low after a load press
// DPRESS | Done high (end of program or tape)
// DGAP   | Done low after a Done press
// STEP   | Next high in the run phase
// SGAP   | Next low between run-phase presses
// FINISH | machine halted or step limit reached
module tm_input_sequencer
  import tm_pkg::*;
#(
  parameter int DATA_W    = TM_DATA_W,
  parameter int ADDR_W    = 7,
  parameter int SETUP_CYC = 3,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int STEP_GAP  = 5,
  parameter int MAX_STEPS = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              Compute_done,
  output logic [DATA_W-1:0] input_data,
  output logic              Next,
  output logic              Done,
  output logic              busy,
  output logic              finished,
  output logic              timeout,
  output logic [7:0]        step_count
);

  localparam logic [3:0] S_IDLE   = ST_IDLE;
  localparam logic [3:0] S_FETCH  = ST_FETCH;
  localparam logic [3:0] S_SETUP  = ST_SETUP;
  localparam logic [3:0] S_PRESS  = ST_PRESS;
  localparam logic [3:0] S_GAP    = ST_GAP;
  localparam logic [3:0] S_DPRESS = ST_DPRESS;
  localparam logic [3:0] S_DGAP   = ST_DGAP;
  localparam logic [3:0] S_STEP   = ST_STEP;
  localparam logic [3:0] S_SGAP   = ST_SGAP;
  localparam logic [3:0] S_FINISH = ST_FINISH;

  localparam int TMAX = max_of4(SETUP_CYC, PULSE_CYC, GAP_CYC, STEP_GAP);
  localparam int TW   = timer_width(TMAX);

  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYC);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC);
  localparam logic [TW-1:0] T_SGAP  = TW'(STEP_GAP);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  logic [3:0]        state, state_n;
  seq_phase_t        phase;
  logic [ADDR_W-1:0] addr, word_cnt, prog_q, tape_q, cur_len;
  logic              fetch_d, last_word, limit_hit;
  logic              tmr_load, expired;
  logic [TW-1:0]     tmr_val;

  assign cur_len   = (phase == PH_PROG) ? prog_q : tape_q;
  assign last_word = ((word_cnt + 1'b1) == cur_len);
  assign limit_hit = (MAX_STEPS != 0) && (step_count == 8'(MAX_STEPS));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_FINISH:
        if (start) state_n = (prog_len == '0) ? S_DPRESS : S_FETCH;
      S_FETCH:  if (fetch_d) state_n = S_SETUP;
      S_SETUP:  if (expired) state_n = S_PRESS;
      S_PRESS:  if (expired) state_n = S_GAP;
      S_GAP:    if (expired) state_n = last_word ? S_DPRESS : S_FETCH;
      S_DPRESS: if (expired) state_n = S_DGAP;
      S_DGAP:
        if (expired) begin
          if (phase == PH_PROG) state_n = (tape_q == '0) ? S_DPRESS : S_FETCH;
          else                  state_n = Compute_done ? S_FINISH : S_STEP;
        end
      S_STEP:   if (expired) state_n = S_SGAP;
      S_SGAP:   if (expired) state_n = (Compute_done || limit_hit) ? S_FINISH : S_STEP;
      default:  state_n = S_IDLE;
    endcase
  end

  // Every transition changes state, so a state change is the timer load strobe.
  always_comb begin
    tmr_load = (state_n != state);
    tmr_val  = T_ONE;
    case (state_n)
      S_SETUP:                   tmr_val = T_SETUP;
      S_PRESS, S_DPRESS, S_STEP: tmr_val = T_PULSE;
      S_GAP, S_DGAP:             tmr_val = T_GAP;
      S_SGAP:                    tmr_val = T_SGAP;
      default:                   tmr_val = T_ONE;
    endcase
  end

  tm_press_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= PH_PROG;
      addr       <= '0;
      word_cnt   <= '0;
      prog_q     <= '0;
      tape_q     <= '0;
      fetch_d    <= 1'b0;
      input_data <= '0;
      step_count <= '0;
      timeout    <= 1'b0;
    end else begin
      state   <= state_n;
      fetch_d <= (state == S_FETCH) && !fetch_d;
      if (state_n == S_STEP && state != S_STEP && step_count != 8'hFF)
        step_count <= step_count + 8'd1;
      if (state == S_SGAP && expired && !Compute_done && limit_hit)
        timeout <= 1'b1;
      case (state)
        S_IDLE, S_FINISH:
          if (start) begin
            prog_q     <= prog_len;
            tape_q     <= tape_len;
            addr       <= '0;
            word_cnt   <= '0;
            phase      <= PH_PROG;
            step_count <= '0;
            timeout    <= 1'b0;
          end
        S_FETCH: if (fetch_d) input_data <= mem_data;
        S_GAP:
          if (expired) begin
            addr     <= addr + 1'b1;
            word_cnt <= word_cnt + 1'b1;
          end
        S_DGAP:
          if (expired) begin
            if (phase == PH_PROG) begin
              phase    <= PH_TAPE;
              addr     <= prog_q;
              word_cnt <= '0;
            end else begin
              phase      <= PH_RUN;
              input_data <= '0;
            end
          end
        default: ;
      endcase
    end
  end

  assign mem_addr = addr;
  assign Next     = (state == S_PRESS) || (state == S_STEP);
  assign Done     = (state == S_DPRESS);
  assign busy     = (state != S_IDLE) && (state != S_FINISH);
  assign finished = (state == S_FINISH);

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Bench for tm_input_sequencer: expected press lists and their cycle times are
// derived arithmetically from the program/tape lengths and the protocol timing.
`timescale 1ns/1ps
module tb_tm_input_sequencer;

  localparam int AW = 7;
  localparam int DW = 6;
  localparam int SETUP = 3;
  localparam int PULSE = 2;
  localparam int GAP   = 2;
  localparam int SGAP  = 5;
  localparam int WORD_SLOT = 2 + SETUP + PULSE + GAP;
  localparam int RISE_OFS  = 2 + SETUP;
  localparam int DONE_SLOT = PULSE + GAP;
  localparam int STEP_PER  = PULSE + SGAP;

  typedef struct packed { int kind; int data; int at; } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_lim = 1'b0;
  logic Compute_done = 1'b0;
  logic cd_lim = 1'b0;
  logic [AW-1:0] prog_len = '0, tape_len = '0, lim_len = '0;
  logic [AW-1:0] mem_addr, mem_addr_l;
  logic [DW-1:0] mem_data = '0, mem_data_l = '0;
  logic [DW-1:0] input_data, input_data_l;
  logic Next, Done, busy, finished, timeout;
  logic Next_l, Done_l, busy_l, finished_l, timeout_l;
  logic [7:0] step_count, step_count_l;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0, t0 = 0;
  logic mon_en = 1'b0, cd_arm = 1'b0;
  int stop_after = 0, run_cnt = 0, done_cnt = 0, rise_at = 0, stable = 0, fin_at = -1;
  int lim_presses = 0;
  logic prev_next = 1'b0, prev_done = 1'b0, prev_next_l = 1'b0;
  logic [DW-1:0] prev_din = '0;
  ev_t got_q[$];
  int width_q[$];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_data   <= mem[mem_addr];
    mem_data_l <= mem[mem_addr_l];
  end

  tm_input_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .prog_len(prog_len), .tape_len(tape_len),
    .mem_addr(mem_addr), .mem_data(mem_data), .Compute_done(Compute_done),
    .input_data(input_data), .Next(Next), .Done(Done), .busy(busy), .finished(finished),
    .timeout(timeout), .step_count(step_count)
  );

  tm_input_sequencer #(.MAX_STEPS(3)) dut_lim (
    .clock(clock), .reset(reset), .start(start_lim), .prog_len(lim_len), .tape_len(lim_len),
    .mem_addr(mem_addr_l), .mem_data(mem_data_l), .Compute_done(cd_lim),
    .input_data(input_data_l), .Next(Next_l), .Done(Done_l), .busy(busy_l),
    .finished(finished_l), .timeout(timeout_l), .step_count(step_count_l)
  );

  function automatic ev_t mk_ev(input int kind, input int data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    return e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, watch invariants, log presses, drive Compute_done.
  task automatic tick();
    @(negedge clock);
    cyc++;
    check("nd_excl", int'(Next & Done), 0);
    check("nd_excl_lim", int'(Next_l & Done_l), 0);
    if (Next && prev_next) check("din_hold", int'(input_data), int'(prev_din));
    if (mon_en) begin
      if ((Next && !prev_next) || (Done && !prev_done)) begin
        got_q.push_back(mk_ev(Next ? 1 : 2, int'(input_data), cyc - t0));
        rise_at = cyc;
        if (Next && done_cnt < 2) check("setup_len", int'(stable >= SETUP), 1);
        if (Next && done_cnt >= 2) run_cnt++;
        if (Done) done_cnt++;
      end
      if ((!Next && prev_next) || (!Done && prev_done)) width_q.push_back(cyc - rise_at);
      if (finished && fin_at < 0) fin_at = cyc - t0;
    end
    stable = (input_data != prev_din) ? 1 : stable + 1;
    if (Next_l && !prev_next_l) lim_presses++;
    prev_next   = Next;
    prev_done   = Done;
    prev_din    = input_data;
    prev_next_l = Next_l;
    Compute_done = cd_arm && !Next && (run_cnt >= stop_after);
  endtask

  task automatic run_seq(input int p, input int t, input int n_stop, input int poke_at);
    ev_t exp_q[$];
    int tt0, r0, fin_exp, n;
    got_q.delete();
    width_q.delete();
    run_cnt = 0; done_cnt = 0; fin_at = -1;
    stop_after = n_stop;
    cd_arm = 1'b1;
    prog_len = AW'(p);
    tape_len = AW'(t);
    for (int k = 0; k < p; k++) exp_q.push_back(mk_ev(1, int'(mem[k]), WORD_SLOT * k + RISE_OFS));
    exp_q.push_back(mk_ev(2, 0, WORD_SLOT * p));
    tt0 = WORD_SLOT * p + DONE_SLOT;
    for (int j = 0; j < t; j++) exp_q.push_back(mk_ev(1, int'(mem[p + j]), tt0 + WORD_SLOT * j + RISE_OFS));
    exp_q.push_back(mk_ev(2, 0, tt0 + WORD_SLOT * t));
    r0 = tt0 + WORD_SLOT * t + DONE_SLOT;
    for (int i = 0; i < n_stop; i++) exp_q.push_back(mk_ev(1, 0, r0 + STEP_PER * i));
    fin_exp = r0 + STEP_PER * n_stop;

    t0 = cyc + 1;
    mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on", int'(busy), 1);
    check("fin_clr", int'(finished), 0);
    check("to_clr", int'(timeout), 0);
    while (fin_at < 0 && (cyc - t0) < fin_exp + 50) begin
      start = (poke_at >= 0 && (cyc - t0) == poke_at);
      tick();
    end
    start = 1'b0;
    check("fin_time", fin_at, fin_exp);
    check("n_ev", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("ev%0d_kind", i), got_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == 1) check($sformatf("ev%0d_data", i), got_q[i].data, exp_q[i].data);
      check($sformatf("ev%0d_at", i), got_q[i].at, exp_q[i].at);
    end
    check("n_width", width_q.size(), exp_q.size());
    foreach (width_q[i]) check($sformatf("w%0d", i), width_q[i], PULSE);
    check("steps", int'(step_count), n_stop);
    check("finished", int'(finished), 1);
    check("busy_off", int'(busy), 0);
    check("timeout", int'(timeout), 0);
    check("next_low", int'(Next), 0);
    mon_en = 1'b0;
    cd_arm = 1'b0;
    Compute_done = 1'b0;
    tick();
  endtask

  initial begin
    int w;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(0, 63));

    // Reset state of both instances
    repeat (3) tick();
    check("rst_next", int'(Next), 0);
    check("rst_done", int'(Done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fin", int'(finished), 0);
    check("rst_to", int'(timeout), 0);
    check("rst_steps", int'(step_count), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_din", int'(input_data), 0);
    check("rst_lim_busy", int'(busy_l), 0);
    check("rst_lim_fin", int'(finished_l), 0);
    reset = 1'b0;
    tick();

    // Step limit with Compute_done stuck low
    lim_presses = 0;
    start_lim = 1'b1;
    tick();
    start_lim = 1'b0;
    w = 0;
    while (!finished_l && w < 200) begin tick(); w++; end
    check("lim_fin", int'(finished_l), 1);
    check("lim_to", int'(timeout_l), 1);
    check("lim_steps", int'(step_count_l), 3);
    check("lim_presses", lim_presses, 3);
    start_lim = 1'b1;
    tick();
    start_lim = 1'b0;
    check("lim_to_clr", int'(timeout_l), 0);
    check("lim_fin_clr", int'(finished_l), 0);
    check("lim_busy", int'(busy_l), 1);

    // Directed program 3,1 / tape 2
    mem[0] = 6'd3; mem[1] = 6'd1; mem[2] = 6'd2;
    run_seq(2, 1, 2, -1);
    // Empty program and tape
    run_seq(0, 0, 1, -1);
    // Machine halts after the fourth step
    run_seq(1, 1, 4, -1);
    // Already halted on run entry
    run_seq(1, 0, 0, -1);
    // start during the tape phase is ignored
    run_seq(2, 2, 1, 2 * WORD_SLOT + DONE_SLOT + 2);

    // Reset during a load press, then replay from address 0
    prog_len = 7'd2;
    tape_len = 7'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!Next && w < 50) begin tick(); w++; end
    check("rst_reach_press", int'(Next), 1);
    reset = 1'b1;
    tick();
    check("abort_next", int'(Next), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_fin", int'(finished), 0);
    check("abort_addr", int'(mem_addr), 0);
    reset = 1'b0;
    tick();
    run_seq(2, 1, 1, -1);

    // Randomized lengths, images and halt points
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom_range(0, 63));
      run_seq(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
